// File: rtl/bist_pkg.sv
// Shared types and defaults for the scan-chain BIST controller and its benches.
package bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_UNLOAD  = 3'd3,
        ST_DONE    = 3'd4
    } bist_state_e;

    localparam int unsigned DEF_CHAIN_LEN    = 8;
    localparam int unsigned DEF_NUM_PATTERNS = 8;
    localparam int unsigned DEF_SIG_W        = 8;
    localparam logic [7:0]  DEF_MISR_POLY    = 8'h1D;

    // Cycles from the accepting start edge until done is visible.
    function automatic int unsigned bist_run_cycles(input int unsigned chain_len,
                                                    input int unsigned num_patterns);
        return num_patterns * (chain_len + 1) + chain_len + 1;
    endfunction

endpackage

// File: rtl/bist_scan_controller_misr.sv
// Serial-input MISR compacting the scan chain's returning bit stream.
module bist_misr #(
    parameter int unsigned      SIG_W     = 8,
    parameter logic [SIG_W-1:0] MISR_POLY = SIG_W'(8'h1D)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_next;

    // Shift left, fold the MSB back through the taps, xor in the serial bit.
    always_comb begin
        sig_next = {sig[SIG_W-2:0], 1'b0}
                 ^ (sig[SIG_W-1] ? MISR_POLY : '0)
                 ^ {{(SIG_W-1){1'b0}}, din};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/bist_scan_controller.sv
// Scan-chain BIST sequencer: shift/capture schedule, scan_en drive and MISR signature.
// Optional signature comparator enabled by defining BIST_CTRL_SIG_CHECK_EN.
module bist_scan_controller
    import bist_pkg::*;
#(
    parameter int unsigned      CHAIN_LEN    = DEF_CHAIN_LEN,
    parameter int unsigned      NUM_PATTERNS = DEF_NUM_PATTERNS,
    parameter int unsigned      SIG_W        = DEF_SIG_W,
    parameter logic [SIG_W-1:0] MISR_POLY    = SIG_W'(DEF_MISR_POLY),
    parameter logic [SIG_W-1:0] GOLDEN_SIG   = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             scan_out,
    output logic             scan_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature
);

    localparam int unsigned BIT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam int unsigned PAT_W = $clog2(NUM_PATTERNS + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CHAIN_LEN - 1);
    localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(NUM_PATTERNS);

    bist_state_e      state_q, state_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [PAT_W-1:0] pat_cnt_q, pat_cnt_d;
    logic [PAT_W-1:0] pat_cnt_inc;
    logic             scan_en_d, busy_d, done_d, pass_d;
    logic             misr_clr_c;
    logic             misr_en_c;

`ifdef BIST_CTRL_SIG_CHECK_EN
    // Signature after the final unload update, so pass lines up with done.
    logic [SIG_W-1:0] sig_last;
    assign sig_last = {signature[SIG_W-2:0], 1'b0}
                    ^ (signature[SIG_W-1] ? MISR_POLY : '0)
                    ^ {{(SIG_W-1){1'b0}}, scan_out};
`else
    logic unused_golden;
    assign unused_golden = ^GOLDEN_SIG;
`endif

    assign pat_cnt_inc = PAT_W'(pat_cnt_q + 1'b1);
    // The first load carries unknown post-reset chain contents and is never compacted.
    assign misr_en_c   = scan_en & (pat_cnt_q != '0);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        pat_cnt_d  = pat_cnt_q;
        scan_en_d  = scan_en;
        busy_d     = busy;
        done_d     = done;
        pass_d     = pass;
        misr_clr_c = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_SHIFT;
                    bit_cnt_d  = '0;
                    pat_cnt_d  = '0;
                    misr_clr_c = 1'b1;
                    scan_en_d  = 1'b1;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                end
            end
            ST_SHIFT: begin
                bit_cnt_d = BIT_W'(bit_cnt_q + 1'b1);
                if (bit_cnt_q == BIT_LAST) begin
                    state_d   = ST_CAPTURE;
                    scan_en_d = 1'b0;
                end
            end
            ST_CAPTURE: begin
                pat_cnt_d = pat_cnt_inc;
                bit_cnt_d = '0;
                scan_en_d = 1'b1;
                state_d   = (pat_cnt_inc == PAT_LAST) ? ST_UNLOAD : ST_SHIFT;
            end
            ST_UNLOAD: begin
                bit_cnt_d = BIT_W'(bit_cnt_q + 1'b1);
                if (bit_cnt_q == BIT_LAST) begin
                    state_d   = ST_DONE;
                    scan_en_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
`ifdef BIST_CTRL_SIG_CHECK_EN
                    pass_d    = (sig_last == GOLDEN_SIG);
`else
                    pass_d    = 1'b0;
`endif
                end
            end
            default: begin
                state_d   = ST_IDLE;
                scan_en_d = 1'b0;
                busy_d    = 1'b0;
                done_d    = 1'b0;
                pass_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            pat_cnt_q <= '0;
            scan_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            pat_cnt_q <= pat_cnt_d;
            scan_en   <= scan_en_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
        end
    end

    bist_misr #(
        .SIG_W     (SIG_W),
        .MISR_POLY (MISR_POLY)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (misr_clr_c),
        .en    (misr_en_c),
        .din   (scan_out),
        .sig   (signature)
    );

endmodule

// File: tb/tb_bist_scan_controller.sv
// Self-checking bench: two controller configurations against a schedule-level model.
module tb_bist_scan_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic scan_out = 1'b0;

    logic se0, bz0, dn0, ps0, se1, bz1, dn1, ps1;
    logic [7:0] sg0, sg1;

    int errors = 0;
    int checks = 0;
    int so_mode = 0;
    logic [15:0] so_pat = 16'hB4E1;

`ifdef BIST_CTRL_SIG_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    bist_scan_controller #(
        .CHAIN_LEN(8), .NUM_PATTERNS(8), .SIG_W(8), .MISR_POLY(8'h1D), .GOLDEN_SIG(8'h00)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .scan_out(scan_out),
        .scan_en(se0), .busy(bz0), .done(dn0), .pass(ps0), .signature(sg0)
    );

    bist_scan_controller #(
        .CHAIN_LEN(2), .NUM_PATTERNS(1), .SIG_W(8), .MISR_POLY(8'h1D), .GOLDEN_SIG(8'h5A)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .scan_out(scan_out),
        .scan_en(se1), .busy(bz1), .done(dn1), .pass(ps1), .signature(sg1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cl_of(input int i);
        return (i == 0) ? 8 : 2;
    endfunction
    function automatic int np_of(input int i);
        return (i == 0) ? 8 : 1;
    endfunction
    function automatic logic [7:0] gold_of(input int i);
        return (i == 0) ? 8'h00 : 8'h5A;
    endfunction

    // Interval t of a run (t=1 right after the start edge): patterns of CL shifts + 1 capture, then CL unload shifts.
    function automatic bit exp_en(input int i, input int t);
        if (t <= np_of(i) * (cl_of(i) + 1)) return (t % (cl_of(i) + 1)) != 0;
        return 1'b1;
    endfunction

    function automatic logic [7:0] misr_step(input logic [7:0] s, input logic d);
        logic [8:0] w;
        w = {1'b0, s} * 2;
        return w[7:0] ^ (s[7] ? 8'h1D : 8'h00) ^ {7'd0, d};
    endfunction

    // Behavioural model: interval index within a run plus the compacted signature.
    bit         m_run  [2];
    int         m_t    [2];
    bit         m_done [2];
    bit         m_pass [2];
    logic [7:0] m_sig  [2];

    always @(posedge clk or negedge rst_n) begin
        bit r, dn, ps;
        int t;
        logic [7:0] s;
        for (int i = 0; i < 2; i++) begin
            r = m_run[i]; t = m_t[i]; dn = m_done[i]; ps = m_pass[i]; s = m_sig[i];
            if (!rst_n) begin
                r = 1'b0; t = 0; dn = 1'b0; ps = 1'b0; s = 8'h00;
            end else if (!r) begin
                if (start) begin
                    r = 1'b1; t = 1; dn = 1'b0; ps = 1'b0; s = 8'h00;
                end
            end else begin
                if (exp_en(i, t) && t > cl_of(i) + 1) s = misr_step(s, scan_out);
                if (t == np_of(i) * (cl_of(i) + 1) + cl_of(i)) begin
                    r = 1'b0; dn = 1'b1; ps = (s == gold_of(i));
                end else begin
                    t = t + 1;
                end
            end
            m_run[i] <= r; m_t[i] <= t; m_done[i] <= dn; m_pass[i] <= ps; m_sig[i] <= s;
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        logic [4:0] act;
        logic [7:0] asg;
        bit e_en;
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                act  = (i == 0) ? {se0, bz0, dn0, ps0, 1'b0} : {se1, bz1, dn1, ps1, 1'b0};
                asg  = (i == 0) ? sg0 : sg1;
                e_en = m_run[i] ? exp_en(i, m_t[i]) : 1'b0;
                chk($sformatf("u%0d.scan_en", i), 32'(act[4]), 32'(e_en));
                chk($sformatf("u%0d.busy", i), 32'(act[3]), 32'(m_run[i]));
                chk($sformatf("u%0d.done", i), 32'(act[2]), 32'(m_done[i]));
                chk($sformatf("u%0d.pass", i), 32'(act[1]), 32'(m_pass[i] & CHECK_EN));
                chk($sformatf("u%0d.signature", i), 32'(asg), 32'(m_sig[i]));
            end
        end
    end

    // Scan chain stand-in: constant 0, constant 1, or a fixed 16-bit pattern.
    initial begin
        int k;
        k = 0;
        forever begin
            @(posedge clk);
            #2;
            k++;
            case (so_mode)
                0:       scan_out = 1'b0;
                1:       scan_out = 1'b1;
                default: scan_out = so_pat[k % 16];
            endcase
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called in interval T+1; returns the interval index where dut0 done is seen.
    task automatic wait_done(input int repulse_at, output int n, output int hi, output int lo);
        n = 1; hi = 0; lo = 0;
        while (n < 200) begin
            if (dn0) break;
            if (se0) hi++; else lo++;
            @(posedge clk);
            #1;
            n++;
            start = (n == repulse_at);
        end
        start = 1'b0;
        if (!dn0) begin
            errors++;
            $display("FAIL done_timeout: done never rose within %0d cycles", n);
        end
    endtask

    initial begin
        int n, hi, lo;
        #1;
        chk("rst scan_en", 32'(se0), 0);
        chk("rst busy", 32'(bz0), 0);
        chk("rst done", 32'(dn0), 0);
        chk("rst pass", 32'(ps0), 0);
        chk("rst signature", 32'(sg0), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("idle busy", 32'({bz0, bz1}), 0);
        chk("idle signature", 32'({sg0, sg1}), 0);

        // Patterned stream: schedule shape and done latency.
        so_mode = 2;
        pulse_start();
        wait_done(0, n, hi, lo);
        chk("A done interval", 32'(n), 81);
        chk("A scan_en high", 32'(hi), 72);
        chk("A scan_en low", 32'(lo), 8);

        // All-zero stream: signature stays 0.
        so_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        pulse_start();
        wait_done(0, n, hi, lo);
        chk("B done interval", 32'(n), 81);
        chk("B signature", 32'(sg0), 8'h00);
        chk("B pass", 32'(ps0), 32'(CHECK_EN));
        chk("B small signature", 32'(sg1), 8'h00);

        // All-ones stream with a mid-run start that must be ignored.
        so_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        pulse_start();
        wait_done(20, n, hi, lo);
        chk("C done interval", 32'(n), 81);
        chk("C scan_en high", 32'(hi), 72);
        chk("C small signature", 32'(sg1), 8'h03);
        chk("C small pass", 32'(ps1), 0);
        chk("C small done", 32'(dn1), 1);

        // Start while in DONE restarts at once.
        pulse_start();
        chk("restart done", 32'(dn0), 0);
        chk("restart signature", 32'(sg0), 8'h00);
        chk("restart scan_en", 32'(se0), 1);
        wait_done(0, n, hi, lo);
        chk("restart done interval", 32'(n), 81);

        // Asynchronous reset mid-run, then a fresh full run.
        so_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        pulse_start();
        repeat (39) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst scan_en", 32'({se0, se1}), 0);
        chk("arst busy", 32'({bz0, bz1}), 0);
        chk("arst done", 32'({dn0, dn1}), 0);
        chk("arst pass", 32'({ps0, ps1}), 0);
        chk("arst signature", 32'({sg0, sg1}), 0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        pulse_start();
        wait_done(0, n, hi, lo);
        chk("D done interval", 32'(n), 81);
        chk("D scan_en high", 32'(hi), 72);
        chk("D scan_en low", 32'(lo), 8);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bist_scan_controller.md
# bist_scan_controller

Autonomous sequencer for the on-chip scan-chain self-test. On a `start` pulse, it runs the scan chain through a fixed schedule:

- shift for `CHAIN_LEN` cycles, then capture for 1 cycle;
- repeat for `NUM_PATTERNS` patterns;
- then shift once more to unload the last capture.

It drives `scan_en` for the chain and compacts the returning `scan_out` stream into a MISR signature. It sits between the top-level test-mode logic and the `Built_In_Self_Test` chain, replacing hand-driven `scan_en` sequences.

## Interface
- `CHAIN_LEN`, default 8: number of flops in the scan chain.
- `NUM_PATTERNS`, default 8: number of shift+capture rounds.
- `SIG_W`, default 8: MISR / signature width.
- `MISR_POLY`, default 8'h1D: feedback taps, applied when the MISR MSB is 1.
- `GOLDEN_SIG`, default 8'h00: expected final signature.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a run; sampled only in IDLE or DONE.
- `scan_out` in 1: serial output of the scan chain.
- `scan_en` out 1: 1 = shift, 0 = capture/hold; registered.
- `busy` out 1: run in progress.
- `done` out 1: run complete; level-held until the next accepted `start` or reset.
- `pass` out 1: signature matches `GOLDEN_SIG`; valid only while `done` = 1.
- `signature` out SIG_W: current MISR contents.

## Operation
- States: IDLE, SHIFT, CAPTURE, UNLOAD, DONE.
- Counters:
  - `bit_cnt`, width clog2(CHAIN_LEN);
  - `pat_cnt`, width clog2(NUM_PATTERNS+1).
- IDLE/DONE with `start` = 1 → SHIFT. On this transition: `bit_cnt` = 0, `pat_cnt` = 0, MISR cleared to 0, `done` = 0.
- SHIFT: `scan_en` = 1, `bit_cnt`++. When `bit_cnt` = CHAIN_LEN-1 → CAPTURE.
- CAPTURE: `scan_en` = 0 for exactly 1 cycle, `pat_cnt`++, `bit_cnt` = 0.
  - If the new `pat_cnt` = NUM_PATTERNS → UNLOAD, else → SHIFT.
- UNLOAD: `scan_en` = 1 for CHAIN_LEN cycles → DONE.
- DONE: `done` = 1, `busy` = 0, `scan_en` = 0. Stays here until `start`.
- MISR update enable = `scan_en` & (`pat_cnt` ≥ 1). The first load shifts out the unknown post-reset chain contents, so it is never compacted.
- Total MISR updates per run = NUM_PATTERNS × CHAIN_LEN.
- MISR next value = (sig << 1) ^ (sig[SIG_W-1] ? MISR_POLY : 0) ^ {0…, scan_out}. Arithmetic is modulo 2^SIG_W.
- `start` while `busy` is ignored; there is no restart mid-run.
- `start` held high in DONE begins a new run immediately.
- Reset asserted mid-run, asynchronously:
  - state = IDLE;
  - `scan_en`, `busy`, `done`, `pass` = 0;
  - `signature` = 0;
  - all counters = 0.
- The controller does not reset the chain itself. The chain shares `rst_n`.

## Timing
- Reset values: `scan_en` = 0, `busy` = 0, `done` = 0, `pass` = 0, `signature` = 0.
- `start` sampled at edge T:
  - `scan_en` = 1 and `busy` = 1 from T+1;
  - first capture (`scan_en` = 0) at cycle T+CHAIN_LEN+1.
- The k-th capture falls at T + k·(CHAIN_LEN+1), for k = 1…NUM_PATTERNS.
- UNLOAD occupies the next CHAIN_LEN cycles.
- `done` rises at T + NUM_PATTERNS·(CHAIN_LEN+1) + CHAIN_LEN + 1. This is T+81 for the defaults.
- `busy` falls in the same cycle `done` rises.
- `pass` and `signature` are stable in DONE.
- `scan_out` is sampled at the same rising edge that shifts the chain, so the MISR sees the chain's pre-shift serial bit.

## Configuration
- `BIST_CTRL_SIG_CHECK_EN` defined: `pass` = (`signature` == GOLDEN_SIG) & `done`, registered on entry to DONE.
- `BIST_CTRL_SIG_CHECK_EN` undefined: no comparator, `pass` is tied to 0, and the GOLDEN_SIG parameter is unused. Software reads `signature` directly.

## Structure
- Shared package `bist_pkg` holds:
  - state encoding constants (IDLE = 0, SHIFT = 1, CAPTURE = 2, UNLOAD = 3, DONE = 4; 3-bit);
  - default CHAIN_LEN, SIG_W and MISR_POLY;
  - the cycle-count formula constant used by benches.
- One sub-module: `bist_misr` (SIG_W, MISR_POLY). Ports: clk, rst_n, clr, en, din, sig.
- The FSM and counters live in `bist_scan_controller`.

## Test plan
- Reset then idle 10 cycles, `start` = 0 → `scan_en`/`busy`/`done`/`pass` stay 0 and `signature` = 0.
- Defaults, `start` pulse at T → `scan_en` high for 8 cycles, low 1 cycle, ×8, then high 8 cycles:
  - exactly 72 high and 8 single-cycle-low `scan_en` cycles;
  - `done` = 1 at T+81.
- CHAIN_LEN = 2, NUM_PATTERNS = 1, `scan_out` tied 1 → only the 2 UNLOAD cycles compact; `signature` = 8'h03.
- Defaults, `scan_out` tied 0, GOLDEN_SIG = 8'h00, macro defined → `signature` = 0, `pass` = 1. With GOLDEN_SIG = 8'h5A → `pass` = 0.
- `start` re-pulsed at T+20 → ignored; `done` still at T+81. `start` in DONE → `done` drops next cycle and `signature` clears to 0.
- `rst_n` pulsed low at T+40 → all outputs 0 asynchronously. A new `start` after release gives the full 81-cycle run.
